fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Round-robin write-port arbiter in front of the 3-bit FIFO. Shares the
//   single FIFO write port between N requesters and drives one write strobe
//   per accepted word. Honours FIFO full and caps each grant at MAX_BURST
//   words so that no requester starves the others.
//   Sits in the write clock domain; clk is the same net as the FIFO wclk.
// PARAMETERS
//   W          3  data word width; matches the FIFO datin width
//   N          2  number of requesters (2..4)
//   ID_W       1  owner index width; must hold N-1
//   MAX_BURST  4  maximum words written per grant (1..15)
// PORTS
//   clk        in   1      single clock, rising edge; FIFO wclk
//   rst        in   1      synchronous, active-high reset
//   req        in   N      req[i]=1: requester i presents a valid word on din
//   din        in   N*W    packed words; requester i on din[i*W +: W]
//   fifo_full  in   1      FIFO full flag
//   ack        out  N      one-hot; ack[i]=1: requester i's word written this cycle
//   fifo_wr    out  1      FIFO write strobe; FIFO samples it on the same clk edge
//   fifo_datin out  W      word to the FIFO; equals din of the owner
//   busy       out  1      1 while a grant is held (state OWN)
//   owner      out  ID_W   index of the current/last grant holder
// BEHAVIOUR
//   - Registered state: state{IDLE,OWN}, owner, ptr (RR pointer), bcnt (4 bit).
//   - Reset (rst=1 at an edge): state=IDLE, owner=0, ptr=0, bcnt=0.
//     Outputs after reset: fifo_wr=0, ack=0, busy=0, owner=0, fifo_datin=0.
//   - Reset has priority over every other event, including in OWN mid-burst.
//     The in-flight word is not written and not acked.
//   - IDLE: if any req is set, choose the first i with req[i]=1 scanning
//     ptr, ptr+1, ... mod N. Next state OWN, owner=i, bcnt=0.
//     If no req is set, stay in IDLE.
//   - OWN: xfer = req[owner] & ~fifo_full, combinational.
//     fifo_wr=xfer, ack[owner]=xfer, fifo_datin=din[owner] (0 when not in OWN).
//   - Handshake: a requester holds req and din stable until it sees ack.
//     It may change din or drop req on the edge that ends the ack cycle.
//   - Latency: a word is written in the same cycle it is acked. A new grant
//     costs 1 cycle (the IDLE cycle).
//   - On each xfer edge: bcnt <= bcnt+1.
//   - Release from OWN to IDLE, ptr <= (owner+1) mod N, when either:
//     (a) xfer and bcnt+1 == MAX_BURST, or
//     (b) req[owner]=0.
//     Release always passes through one IDLE bubble cycle.
//   - fifo_full=1 in OWN: no write, no ack, bcnt held, grant kept. There is
//     no timeout. Writes resume on the first cycle full drops, if req is
//     still set. If req drops while full, rule (b) releases the grant.
//   - Non-owner requests are ignored until the next IDLE cycle.
//     Their ack stays 0.
//   - ptr wraps N-1 -> 0. owner keeps its value while in IDLE.
// TESTING
//   1 reset, then req=2'b11 -> IDLE 1 cycle, then owner=0, busy=1, and
//     fifo_wr pulses with requester 0's data first.
//   2 req0 only, words 2,6,4,1,7, MAX_BURST=4 -> fifo_wr high 4 consecutive
//     cycles writing 2,6,4,1; 1 idle cycle; regrant owner 0; 7 written.
//   3 req=2'b11 held -> 4 writes owner 0, bubble, 4 writes owner 1, bubble,
//     owner 0 again; ack never set for 2 bits at once.
//   4 fifo_full=1 for 3 cycles after 2nd word of a burst -> fifo_wr=0 and
//     ack=0 for 3 cycles, owner unchanged; then exactly 2 more writes,
//     then release.
//   5 owner 1 drops req after 2 writes -> next cycle busy=0, ptr=0;
//     a waiting req0 is granted on the following cycle.
//   6 rst pulsed in OWN with req held -> next cycle busy=0, ack=0,
//     fifo_wr=0, owner=0, ptr=0; no spurious FIFO write.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port between N requesters.
// Each grant is capped at MAX_BURST words, and every release passes through one IDLE cycle.
module fifo_wr_arbiter #(
  parameter int W         = 3,
  parameter int N         = 2,
  parameter int ID_W      = 1,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  input  logic            fifo_full,
  output logic [N-1:0]    ack,
  output logic            fifo_wr,
  output logic [W-1:0]    fifo_datin,
  output logic            busy,
  output logic [ID_W-1:0] owner
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0]      BURST_LAST = 4'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] OWNER_LAST = ID_W'(N - 1);

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [3:0]      bcnt;

  logic            own_req;
  logic            xfer;
  logic            pick_valid;
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] next_ptr;

  // Scan from ptr upward; the loop runs downward so the nearest requester wins.
  always_comb begin
    pick       = ptr;
    pick_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        pick       = ID_W'((int'(ptr) + k) % N);
        pick_valid = 1'b1;
      end
    end
  end

  // A word presented while reset is asserted must never reach the FIFO.
  assign own_req  = req[owner];
  assign xfer     = (state == OWN) && own_req && !fifo_full && !rst;
  assign next_ptr = (owner == OWNER_LAST) ? '0 : owner + 1'b1;
  assign busy     = (state == OWN);

  always_comb begin
    ack        = '0;
    fifo_wr    = xfer;
    fifo_datin = '0;
    if (state == OWN) begin
      fifo_datin = din[int'(owner)*W +: W];
    end
    if (xfer) begin
      ack[owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      bcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= OWN;
            owner <= pick;
            bcnt  <= '0;
          end
        end
        OWN: begin
          if (xfer) begin
            bcnt <= bcnt + 4'd1;
          end
          // A full FIFO stalls the burst but keeps the grant; only the cap or a dropped req ends it.
          if ((xfer && bcnt == BURST_LAST) || !own_req) begin
            state <= IDLE;
            ptr   <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: requester agents feed words and
// a scoreboard holds the expected (owner, data) order of FIFO writes.
module tb_fifo_wr_arbiter;

  localparam int W         = 3;
  localparam int N         = 2;
  localparam int ID_W      = 1;
  localparam int MAX_BURST = 4;

  typedef struct {
    int owner;
    int data;
  } wr_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*W-1:0]  din = '0;
  logic            fifo_full = 1'b0;
  logic [N-1:0]    ack;
  logic            fifo_wr;
  logic [W-1:0]    fifo_datin;
  logic            busy;
  logic [ID_W-1:0] owner;

  int checks = 0;
  int errors = 0;

  wr_t sb[$];
  int  srcQ0[$];
  int  srcQ1[$];
  logic [N-1:0] reqEn = '1;

  logic         wrS;
  logic [N-1:0] ackS = '0;
  logic [W-1:0] datS;
  logic         busyS;
  logic [ID_W-1:0] ownerS;

  fifo_wr_arbiter #(.W(W), .N(N), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .fifo_full(fifo_full),
    .ack(ack), .fifo_wr(fifo_wr), .fifo_datin(fifo_datin), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    req[0] = reqEn[0] && (srcQ0.size() > 0);
    req[1] = reqEn[1] && (srcQ1.size() > 0);
    din[0*W +: W] = (srcQ0.size() > 0) ? W'(srcQ0[0]) : '0;
    din[1*W +: W] = (srcQ1.size() > 0) ? W'(srcQ1[0]) : '0;
  endtask

  task automatic expectWr(input int o, input int d);
    wr_t e;
    e.owner = o;
    e.data  = d;
    sb.push_back(e);
  endtask

  // One clock cycle: retire acked words, drive inputs, then sample mid-cycle.
  task automatic tick(input logic full, input logic rstv);
    wr_t e;
    @(posedge clk);
    #1;
    if (ackS[0] && srcQ0.size() > 0) void'(srcQ0.pop_front());
    if (ackS[1] && srcQ1.size() > 0) void'(srcQ1.pop_front());
    rst       = rstv;
    fifo_full = full;
    applyStimulus();
    @(negedge clk);
    wrS    = fifo_wr;
    ackS   = ack;
    datS   = fifo_datin;
    busyS  = busy;
    ownerS = owner;
    if (wrS) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_wr", 32'(wrS), 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_data", 32'(datS), 32'(e.data));
        checkOutput("wr_owner", 32'(ownerS), 32'(e.owner));
        checkOutput("wr_ack_onehot", 32'(ackS), 32'(1 << e.owner));
      end
    end else begin
      checkOutput("ack_without_wr", 32'(ackS), 32'd0);
    end
  endtask

  task automatic runCycles(input string tag, input string pat, input logic full);
    for (int c = 0; c < pat.len(); c++) begin
      tick(full, 1'b0);
      checkOutput($sformatf("%s_wr_c%0d", tag, c), 32'(wrS), 32'(pat[c] == 8'h31));
    end
  endtask

  initial begin
    // Reset
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    checkOutput("rst_busy", 32'(busyS), 32'd0);
    checkOutput("rst_owner", 32'(ownerS), 32'd0);
    checkOutput("rst_wr", 32'(wrS), 32'd0);
    checkOutput("rst_ack", 32'(ackS), 32'd0);
    checkOutput("rst_datin", 32'(datS), 32'd0);

    // Both requesting: bursts of 4 alternate with one bubble in between
    srcQ0 = '{1, 2, 3, 4, 5};
    srcQ1 = '{6, 7, 0, 3, 2};
    expectWr(0, 1); expectWr(0, 2); expectWr(0, 3); expectWr(0, 4);
    expectWr(1, 6); expectWr(1, 7); expectWr(1, 0); expectWr(1, 3);
    expectWr(0, 5); expectWr(1, 2);
    runCycles("rr_first", "0", 1'b0);
    checkOutput("rr_idle_busy", 32'(busyS), 32'd0);
    runCycles("rr_grant", "1", 1'b0);
    checkOutput("rr_grant_busy", 32'(busyS), 32'd1);
    checkOutput("rr_grant_owner", 32'(ownerS), 32'd0);
    runCycles("rr", "111011110100100", 1'b0);
    checkOutput("rr_owner_held_idle", 32'(ownerS), 32'd1);
    checkOutput("rr_sb_empty", 32'(sb.size()), 32'd0);

    // Single requester: cap at 4, bubble, regrant same owner
    srcQ0 = '{2, 6, 4, 1, 7};
    expectWr(0, 2); expectWr(0, 6); expectWr(0, 4); expectWr(0, 1); expectWr(0, 7);
    runCycles("solo", "011110", 1'b0);
    runCycles("solo_regrant", "1", 1'b0);
    checkOutput("solo_regrant_owner", 32'(ownerS), 32'd0);
    runCycles("solo_end", "00", 1'b0);
    checkOutput("solo_sb_empty", 32'(sb.size()), 32'd0);

    // FIFO full stalls mid-burst without losing the grant or burst count
    srcQ1 = '{5, 3, 6, 2, 1};
    expectWr(1, 5); expectWr(1, 3); expectWr(1, 6); expectWr(1, 2); expectWr(1, 1);
    runCycles("full_pre", "011", 1'b0);
    runCycles("full_stall", "000", 1'b1);
    checkOutput("full_owner", 32'(ownerS), 32'd1);
    checkOutput("full_busy", 32'(busyS), 32'd1);
    runCycles("full_resume", "110", 1'b0);
    checkOutput("full_release_busy", 32'(busyS), 32'd0);
    runCycles("full_tail", "100", 1'b0);
    checkOutput("full_sb_empty", 32'(sb.size()), 32'd0);

    // Owner 1 drops req after 2 words; waiting req0 gets the next grant
    srcQ1 = '{4, 1, 6};
    expectWr(1, 4); expectWr(1, 1);
    runCycles("drop_pre", "011", 1'b0);
    reqEn = 2'b01;
    srcQ0 = '{7};
    expectWr(0, 7); expectWr(1, 6);
    runCycles("drop_rel", "0", 1'b0);
    reqEn = 2'b11;
    runCycles("drop_idle", "0", 1'b0);
    checkOutput("drop_idle_busy", 32'(busyS), 32'd0);
    runCycles("drop_grant0", "1", 1'b0);
    checkOutput("drop_grant0_owner", 32'(ownerS), 32'd0);
    runCycles("drop_tail", "00100", 1'b0);
    checkOutput("drop_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-burst with req held: the in-flight word is dropped
    srcQ1 = '{3, 5, 2, 4};
    expectWr(1, 3); expectWr(1, 5); expectWr(1, 2); expectWr(1, 4);
    runCycles("rstmid_pre", "01", 1'b0);
    tick(1'b0, 1'b1);
    checkOutput("rstmid_wr_during_rst", 32'(wrS), 32'd0);
    runCycles("rstmid_after", "0", 1'b0);
    checkOutput("rstmid_busy", 32'(busyS), 32'd0);
    checkOutput("rstmid_owner", 32'(ownerS), 32'd0);
    checkOutput("rstmid_ack", 32'(ackS), 32'd0);
    checkOutput("rstmid_datin", 32'(datS), 32'd0);
    runCycles("rstmid_tail", "11100", 1'b0);
    checkOutput("rstmid_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
